// File: rtl/shift_reg_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_seq
// Description : Sequenced shift/rotate register; multi-step ops run one step
//               per clock with busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_SAR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic [AMT_W-1:0] c_one = {{(AMT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic [2:0]       r_op;
    logic             r_sin;
    logic [AMT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_is_shift;
    logic             w_amt_nz;
    logic             w_last;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_sout;
    logic             w_busy;
    logic             w_done;

    assign w_accept   = start & (r_state == IDLE);
    assign w_is_shift = (op != OP_HOLD) && (op != OP_LOAD) && (op != OP_CLR);
    assign w_amt_nz   = |amt;
    assign w_last     = (r_cnt == c_one);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_is_shift && w_amt_nz) ? RUN : DONE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE);
        w_done = (r_state == DONE);
    end

    // Single step of the latched operation; uses the latched fill bit, not sin
    always_comb begin
        w_step_q    = r_q;
        w_step_sout = r_sout;
        case (r_op)
            OP_SHL: begin
                w_step_q    = {r_q[WIDTH-2:0], r_sin};
                w_step_sout = r_q[WIDTH-1];
            end
            OP_SHR: begin
                w_step_q    = {r_sin, r_q[WIDTH-1:1]};
                w_step_sout = r_q[0];
            end
            OP_SAR: begin
                w_step_q    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_step_sout = r_q[0];
            end
            OP_ROL: begin
                w_step_q    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_step_sout = r_q[WIDTH-1];
            end
            OP_ROR: begin
                w_step_q    = {r_q[0], r_q[WIDTH-1:1]};
                w_step_sout = r_q[0];
            end
            default: begin
                w_step_q    = r_q;
                w_step_sout = r_sout;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_sout <= 1'b0;
            r_op   <= OP_HOLD;
            r_sin  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_op  <= op;
            r_sin <= sin;
            r_cnt <= w_is_shift ? amt : '0;
            if (op == OP_LOAD) begin
                r_q <= d;
            end else if (op == OP_CLR) begin
                r_q    <= '0;
                r_sout <= 1'b0;
            end
        end else if (r_state == RUN) begin
            r_q    <= w_step_q;
            r_sout <= w_step_sout;
            r_cnt  <= r_cnt - c_one;
        end
    end

    assign q    = r_q;
    assign sout = r_sout;
    assign busy = w_busy;
    assign done = w_done;

endmodule
`default_nettype wire
